mux_scanner: RTL and testbench

Sequencer that sits directly in front of the 8:1 select mux. It drives the mux's 3-bit select, waits a programmable settle time per channel, samples the single-bit mux output, and assembles the enabled channels into an 8-bit parallel word. A start/busy/done handshake lets the top level request one full scan at a time.

---
 rtl/mux_scanner_pkg.sv | 16 +
 rtl/mux_scanner_next_chan.sv | 29 ++
 rtl/mux_scanner.sv | 139 +++++++++++++
 tb/tb_mux_scanner.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/mux_scanner_pkg.sv
// Shared definitions for the mux scanner: channel count, select width,
// settle-counter width and the FSM state encoding.
package mux_scanner_pkg;

  localparam int unsigned N_CH  = 8;
  localparam int unsigned SEL_W = 3;
  localparam int unsigned CNT_W = 4;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    DWELL   = 2'd1,
    CAPTURE = 2'd2,
    DONE    = 2'd3
  } state_e;

endpackage

// File: rtl/mux_scanner_next_chan.sv
// Channel picker for the scanner: returns the next enabled channel.
//   mask_q : enabled channels
//   cur    : current select
//   first  : 1 = lowest enabled channel, 0 = lowest enabled above cur
//   nxt    : picked channel index (0 when none)
//   found  : a channel was picked
module next_chan
  import mux_scanner_pkg::*;
(
  input  logic [N_CH-1:0]  mask_q,
  input  logic [SEL_W-1:0] cur,
  input  logic             first,
  output logic [SEL_W-1:0] nxt,
  output logic             found
);

  // Scan from the top down so the lowest qualifying index wins.
  always_comb begin
    nxt   = '0;
    found = 1'b0;
    for (int i = N_CH - 1; i >= 0; i--) begin
      if (mask_q[i] && (first || (SEL_W'(i) > cur))) begin
        nxt   = SEL_W'(i);
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mux_scanner.sv
// Sequencer in front of an 8:1 select mux. Steps the select through the
// enabled channels in ascending order, waits SETTLE cycles on each, samples
// Y, and publishes the assembled word with a one-cycle done pulse.
//   clk, rst : clock, synchronous active-high reset
//   start    : scan request (honoured only when idle)
//   mask     : channel enables, latched when a scan is accepted
//   Y        : mux output
//   S        : mux select
//   data     : last completed scan word
//   busy     : scan in progress (any state other than idle)
//   done     : one-cycle pulse when data updates
module mux_scanner
  import mux_scanner_pkg::*;
#(
  parameter int unsigned SETTLE = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [N_CH-1:0]  mask,
  input  logic             Y,
  output logic [SEL_W-1:0] S,
  output logic [N_CH-1:0]  data,
  output logic             busy,
  output logic             done
);

  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(SETTLE - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [N_CH-1:0]  shadow_q, shadow_d;
  logic [N_CH-1:0]  mask_q, mask_d;
  logic [SEL_W-1:0] s_q, s_d;
  logic [N_CH-1:0]  data_q, data_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic [N_CH-1:0]  nc_mask;
  logic             nc_first;
  logic [SEL_W-1:0] nc_nxt;
  logic             nc_found;

  // One picker serves both the first pick (live mask) and later picks.
  assign nc_first = (state_q == IDLE);
  assign nc_mask  = nc_first ? mask : mask_q;

  next_chan u_next_chan (
    .mask_q (nc_mask),
    .cur    (s_q),
    .first  (nc_first),
    .nxt    (nc_nxt),
    .found  (nc_found)
  );

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      shadow_q <= '0;
      mask_q   <= '0;
      s_q      <= '0;
      data_q   <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      shadow_q <= shadow_d;
      mask_q   <= mask_d;
      s_q      <= s_d;
      data_q   <= data_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start) state_d = nc_found ? DWELL : DONE;
      DWELL:   if (cnt_q == '0) state_d = CAPTURE;
      CAPTURE: state_d = nc_found ? DWELL : DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Datapath and registered-output next values.
  always_comb begin
    cnt_d    = cnt_q;
    shadow_d = shadow_q;
    mask_d   = mask_q;
    s_d      = s_q;
    data_d   = data_q;
    busy_d   = (state_d != IDLE);
    done_d   = (state_d == DONE);
    unique case (state_q)
      IDLE: begin
        s_d = '0;
        if (start) begin
          mask_d   = mask;
          shadow_d = '0;
          if (nc_found) begin
            s_d   = nc_nxt;
            cnt_d = CNT_LOAD;
          end else begin
            data_d = '0;
          end
        end
      end
      DWELL: begin
        if (cnt_q != '0) cnt_d = cnt_q - CNT_W'(1);
      end
      CAPTURE: begin
        shadow_d[s_q] = Y;
        if (nc_found) begin
          s_d   = nc_nxt;
          cnt_d = CNT_LOAD;
        end else begin
          data_d = shadow_d;
        end
      end
      DONE: begin
        // Select returns to 0 as the scanner drops back to idle.
        s_d = '0;
      end
      default: ;
    endcase
  end

  assign S    = s_q;
  assign data = data_q;
  assign busy = busy_q;
  assign done = done_q;

endmodule

// File: tb/tb_mux_scanner.sv
// Bench for mux_scanner: a scan-level reference model checked every cycle,
// plus directed scenarios with hand-computed results.
module tb_mux_scanner;

  localparam int unsigned SETTLE = 2;
  localparam int          PER    = SETTLE + 1;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [7:0] mask;
  logic [7:0] mux_in;
  logic       Y;
  logic [2:0] S;
  logic [7:0] data;
  logic       busy;
  logic       done;

  int vectors     = 0;
  int miscompares = 0;
  bit chk_en      = 1'b0;

  always #5 clk = ~clk;

  // The mux being sequenced.
  assign Y = mux_in[S];

  mux_scanner #(.SETTLE(SETTLE)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .mask  (mask),
    .Y     (Y),
    .S     (S),
    .data  (data),
    .busy  (busy),
    .done  (done)
  );

  // Reference model: a scan is a list of enabled channels, each owning PER
  // consecutive cycles after acceptance; the last of those samples Y.
  logic [2:0] s_m      = '0;
  logic [7:0] data_m   = '0;
  logic [7:0] shadow_m = '0;
  logic       busy_m   = 1'b0;
  logic       done_m   = 1'b0;
  bit         scanning = 1'b0;
  bit         in_done  = 1'b0;
  int         k        = 0;
  int         chans[$];

  always @(posedge clk) begin
    if (rst) begin
      s_m = '0; data_m = '0; shadow_m = '0; busy_m = 1'b0; done_m = 1'b0;
      scanning = 1'b0; in_done = 1'b0; k = 0;
    end else if (in_done) begin
      in_done = 1'b0; done_m = 1'b0; busy_m = 1'b0; s_m = '0;
    end else if (scanning) begin
      if (k % PER == PER - 1) shadow_m[chans[k / PER]] = Y;
      k++;
      if (k == chans.size() * PER) begin
        data_m = shadow_m; done_m = 1'b1; in_done = 1'b1; scanning = 1'b0;
      end else begin
        s_m = 3'(chans[k / PER]);
      end
    end else if (start) begin
      chans.delete();
      for (int i = 0; i < 8; i++) if (mask[i]) chans.push_back(i);
      shadow_m = '0;
      busy_m   = 1'b1;
      if (chans.size() == 0) begin
        data_m = '0; done_m = 1'b1; in_done = 1'b1; s_m = '0;
      end else begin
        scanning = 1'b1; k = 0; s_m = 3'(chans[0]);
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("S", 32'(S), 32'(s_m));
      chk("data", 32'(data), 32'(data_m));
      chk("busy", 32'(busy), 32'(busy_m));
      chk("done", 32'(done), 32'(done_m));
    end
  end

  // Waits for done; n = edges from the accepting edge to the one raising done.
  task automatic wait_done(output int n);
    n = 0;
    while (!done && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!done) chk("done_timeout", 32'(0), 32'(1));
  endtask

  task automatic scan(input logic [7:0] m, input logic [7:0] i_val,
                      input logic [7:0] exp_data, input int exp_lat, input string tag);
    int n;
    @(negedge clk);
    mask = m; mux_in = i_val; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    wait_done(n);
    chk({tag, "_data"}, 32'(data), 32'(exp_data));
    if (exp_lat >= 0) chk({tag, "_latency"}, 32'(n), 32'(exp_lat));
  endtask

  initial begin
    int n;
    int dones;
    rst = 1'b1; start = 1'b0; mask = '0; mux_in = '0;
    @(posedge clk);
    chk_en = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    chk("rst_S", 32'(S), 32'(0));
    chk("rst_data", 32'(data), 32'(0));
    chk("rst_busy", 32'(busy), 32'(0));
    chk("rst_done", 32'(done), 32'(0));

    // Full scan: 8 channels x 3 cycles.
    scan(8'hFF, 8'hA5, 8'hA5, 24, "full");
    // Only channels 0 and 7.
    scan(8'h81, 8'hFF, 8'h81, 6, "ends");
    // Empty mask: done on the cycle after acceptance with data cleared.
    scan(8'h00, 8'hFF, 8'h00, 0, "empty");

    // start held high: two back-to-back scans, mask churned while busy.
    @(negedge clk);
    mask = 8'hFF; mux_in = 8'h3C; start = 1'b1; dones = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (done) begin
        dones++;
        chk("b2b_data", 32'(data), 32'h3C);
        mask = 8'hFF;
      end else if (busy && (i % 5 == 0)) begin
        mask = 8'(i * 37);
      end
    end
    start = 1'b0; mask = 8'hFF;
    chk("b2b_done_count", 32'(dones), 32'd2);
    n = 0;
    while (busy && n < 100) begin @(negedge clk); n++; end
    if (busy) chk("b2b_idle_timeout", 32'(0), 32'(1));

    // Reset during the dwell on channel 4 abandons the scan.
    @(negedge clk);
    mask = 8'hFF; mux_in = 8'hA5; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    n = 0;
    while (S != 3'd4 && n < 100) begin @(negedge clk); n++; end
    chk("mid_reached_ch4", 32'(S), 32'd4);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("mid_S", 32'(S), 32'(0));
    chk("mid_busy", 32'(busy), 32'(0));
    chk("mid_data", 32'(data), 32'(0));
    chk("mid_done", 32'(done), 32'(0));
    repeat (12) @(negedge clk);

    // Y on channel 2 changes during its dwell; only the captured value counts.
    @(negedge clk);
    mask = 8'h04; mux_in = 8'h00; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0; mux_in = 8'h04;
    wait_done(n);
    chk("late_y_data", 32'(data), 32'h04);
    chk("late_y_latency", 32'(n), 32'd3);

    repeat (3) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1);
  end

endmodule
